// File: rtl/sumador_completo_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : sumador_completo_pkg
//  Brief    : Shared constants and types for the ripple-carry full adder.
//  Revision : 1.0 - initial release
// ============================================================================
package sumador_completo_pkg;

    localparam int c_default_width = 1;
    localparam int c_max_width     = 64;

    // {cout, sum} for the default operand width
    typedef logic [c_default_width:0] result_t;

endpackage
`default_nettype wire

// File: rtl/sumador_completo_bit.sv
`default_nettype none
// ============================================================================
//  Module   : full_adder_bit
//  Brief    : Purely combinational 1-bit full-adder cell.
//  Revision : 1.0 - initial release
// ============================================================================
module full_adder_bit (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (a & cin) | (b & cin);

endmodule
`default_nettype wire

// File: rtl/sumador_completo.sv
`default_nettype none
// ============================================================================
//  Module   : sumador_completo
//  Brief    : WIDTH-bit ripple-carry adder with carry-out, signed overflow and
//             an optional output register stage.
//  Revision : 1.0 - initial release
// ============================================================================
module sumador_completo
    import sumador_completo_pkg::*;
#(
    parameter int WIDTH   = c_default_width,
    parameter int REG_OUT = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    logic [WIDTH:0]   w_carry;
    logic [WIDTH-1:0] w_sum;
    logic             w_ovf;

    assign w_carry[0] = cin;

    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
            full_adder_bit u_fa (
                .a    (a[gi]),
                .b    (b[gi]),
                .cin  (w_carry[gi]),
                .s    (w_sum[gi]),
                .cout (w_carry[gi+1])
            );
        end
    endgenerate

    // For WIDTH=1 the carry into the MSB is cin itself
    assign w_ovf = w_carry[WIDTH] ^ w_carry[WIDTH-1];

    generate
        if (REG_OUT != 0) begin : g_reg
            logic [WIDTH-1:0] r_sum;
            logic             r_cout;
            logic             r_ovf;

            always_ff @(posedge clk) begin
                if (rst) begin
                    r_sum  <= '0;
                    r_cout <= 1'b0;
                    r_ovf  <= 1'b0;
                end else begin
                    r_sum  <= w_sum;
                    r_cout <= w_carry[WIDTH];
                    r_ovf  <= w_ovf;
                end
            end

            assign sum  = r_sum;
            assign cout = r_cout;
            assign ovf  = r_ovf;
        end else begin : g_comb
            logic w_unused;
            assign w_unused = clk ^ rst;

            assign sum  = w_sum;
            assign cout = w_carry[WIDTH];
            assign ovf  = w_ovf;
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_sumador_completo.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sumador_completo
//  Brief    : Scoreboard bench for sumador_completo in four configurations.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_sumador_completo;

    localparam int c_ncyc = 10010;

    typedef struct {
        int          tag;
        logic [15:0] s;
        logic        co;
        logic        ov;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic [0:0]  a1 = '0, b1 = '0;
    logic        cin1 = 1'b0;
    logic [0:0]  s1c, s1r;
    logic        co1c, ov1c, co1r, ov1r;

    logic [7:0]  a8 = '0, b8 = '0, s8;
    logic        cin8 = 1'b0, co8, ov8;

    logic [15:0] a16 = '0, b16 = '0, s16;
    logic        cin16 = 1'b0, co16, ov16;

    exp_t q1c[$], q1r[$], q8[$], q16[$];
    int   n_total = 0;
    int   n_pass  = 0;

    // (cin,a,b) = 000..111 : hand-computed truth table
    logic [7:0] t1_s  = 8'h96;
    logic [7:0] t1_co = 8'hE8;
    logic [7:0] t1_ov = 8'h18;

    // WIDTH=8 directed vectors: carry wrap, +overflow, all-ones+cin, -overflow, zero
    logic [7:0] d_a  [5] = '{8'hFF, 8'h7F, 8'hFF, 8'h80, 8'h00};
    logic [7:0] d_b  [5] = '{8'h01, 8'h01, 8'hFF, 8'h80, 8'h00};
    logic       d_c  [5] = '{1'b0,  1'b0,  1'b1,  1'b0,  1'b0};
    logic [7:0] d_s  [5] = '{8'h00, 8'h80, 8'hFF, 8'h00, 8'h00};
    logic       d_co [5] = '{1'b1,  1'b0,  1'b1,  1'b1,  1'b0};
    logic       d_ov [5] = '{1'b0,  1'b1,  1'b0,  1'b1,  1'b0};

    sumador_completo #(.WIDTH(1), .REG_OUT(0)) u_w1c (
        .clk(clk), .rst(rst), .a(a1), .b(b1), .cin(cin1),
        .sum(s1c), .cout(co1c), .ovf(ov1c)
    );
    sumador_completo #(.WIDTH(1), .REG_OUT(1)) u_w1r (
        .clk(clk), .rst(rst), .a(a1), .b(b1), .cin(cin1),
        .sum(s1r), .cout(co1r), .ovf(ov1r)
    );
    sumador_completo #(.WIDTH(8), .REG_OUT(1)) u_w8 (
        .clk(clk), .rst(rst), .a(a8), .b(b8), .cin(cin8),
        .sum(s8), .cout(co8), .ovf(ov8)
    );
    sumador_completo #(.WIDTH(16), .REG_OUT(1)) u_w16 (
        .clk(clk), .rst(rst), .a(a16), .b(b16), .cin(cin16),
        .sum(s16), .cout(co16), .ovf(ov16)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int tag,
                       input logic [17:0] act, input logic [17:0] req);
        n_total++;
        if (act === req) n_pass++;
        else $display("FAIL %s vec %0d: got {cout,ovf,sum}=%h required %h",
                      name, tag, act, req);
    endtask

    function automatic exp_t model8(int tag, logic [7:0] a, logic [7:0] b, logic c);
        exp_t    e;
        logic [8:0] r = {1'b0, a} + {1'b0, b} + {8'b0, c};
        e.tag = tag;
        e.s   = {8'b0, r[7:0]};
        e.co  = r[8];
        e.ov  = (a[7] == b[7]) && (r[7] != a[7]);
        return e;
    endfunction

    function automatic exp_t model16(int tag, logic [15:0] a, logic [15:0] b, logic c);
        exp_t     e;
        logic [16:0] r = {1'b0, a} + {1'b0, b} + {16'b0, c};
        e.tag = tag;
        e.s   = r[15:0];
        e.co  = r[16];
        e.ov  = (a[15] == b[15]) && (r[15] != a[15]);
        return e;
    endfunction

    function automatic exp_t zero_exp(int tag);
        exp_t e;
        e.tag = tag;
        e.s   = '0;
        e.co  = 1'b0;
        e.ov  = 1'b0;
        return e;
    endfunction

    task automatic drive(input int cyc);
        int   k = cyc % 8;
        exp_t e;
        rst = (cyc < 2) || (cyc == 300) || (cyc == 301);

        cin1 = k[2];
        a1   = k[1];
        b1   = k[0];
        e.tag = cyc;
        e.s   = {15'b0, t1_s[k]};
        e.co  = t1_co[k];
        e.ov  = t1_ov[k];
        q1c.push_back(e);
        q1r.push_back(rst ? zero_exp(cyc) : e);

        if (cyc >= 2 && cyc < 7) begin
            a8   = d_a[cyc-2];
            b8   = d_b[cyc-2];
            cin8 = d_c[cyc-2];
            e.s  = {8'b0, d_s[cyc-2]};
            e.co = d_co[cyc-2];
            e.ov = d_ov[cyc-2];
        end else begin
            a8   = 8'($urandom);
            b8   = 8'($urandom);
            cin8 = 1'($urandom);
            e    = model8(cyc, a8, b8, cin8);
        end
        q8.push_back(rst ? zero_exp(cyc) : e);

        a16   = 16'($urandom);
        b16   = 16'($urandom);
        cin16 = 1'($urandom);
        e     = model16(cyc, a16, b16, cin16);
        q16.push_back(rst ? zero_exp(cyc) : e);
    endtask

    // Monitor: every output sample pops the oldest outstanding expectation
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q1c.size() > 0) begin
                e = q1c.pop_front();
                chk("w1_comb", e.tag, {co1c, ov1c, 15'b0, s1c}, {e.co, e.ov, e.s});
            end
            if (q1r.size() > 0) begin
                e = q1r.pop_front();
                chk("w1_reg", e.tag, {co1r, ov1r, 15'b0, s1r}, {e.co, e.ov, e.s});
            end
            if (q8.size() > 0) begin
                e = q8.pop_front();
                chk("w8_reg", e.tag, {co8, ov8, 8'b0, s8}, {e.co, e.ov, e.s});
            end
            if (q16.size() > 0) begin
                e = q16.pop_front();
                chk("w16_reg", e.tag, {co16, ov16, s16}, {e.co, e.ov, e.s});
            end
        end
    end

    initial begin
        for (int cyc = 0; cyc < c_ncyc; cyc++) begin
            @(negedge clk);
            drive(cyc);
        end
        @(posedge clk);
        #3;
        chk("drain_w1c", 0, 18'(q1c.size()), 18'd0);
        chk("drain_w1r", 0, 18'(q1r.size()), 18'd0);
        chk("drain_w8",  0, 18'(q8.size()),  18'd0);
        chk("drain_w16", 0, 18'(q16.size()), 18'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/sumador_completo.md
Name: sumador_completo

Overview:
- Parameterizable full adder: computes a + b + cin over WIDTH bits, producing sum, carry-out and signed-overflow flag.
- Built as a ripple chain of 1-bit full-adder cells, with an optional output register stage.
- Used as the basic arithmetic leaf for datapath blocks.
- With WIDTH=1 it is the classic single-bit full adder.

Parameters:
- WIDTH, 1, operand and sum width in bits (legal range 1..64).
- REG_OUT, 1, 1 = outputs registered (1-cycle latency); 0 = outputs purely combinational.

Ports:
- clk  input  1  system clock, rising-edge active.
- rst  input  1  synchronous, active-high reset.
- a  input  WIDTH  operand A, unsigned (two's complement for ovf).
- b  input  WIDTH  operand B, unsigned (two's complement for ovf).
- cin  input  1  carry-in to bit 0.
- sum  output  WIDTH  (a + b + cin) mod 2^WIDTH.
- cout  output  1  carry out of bit WIDTH-1.
- ovf  output  1  signed overflow: carry into MSB XOR carry out of MSB.

Behaviour:
- Interface: one clock; reset is synchronous and active-high (clk, rst).
- Per bit i: s[i] = a[i] ^ b[i] ^ c[i].
- Per bit i: c[i+1] = (a[i]&b[i]) | (a[i]&c[i]) | (b[i]&c[i]).
- Chain boundaries: c[0] = cin; cout = c[WIDTH].
- Overflow: ovf = c[WIDTH] ^ c[WIDTH-1]. For WIDTH=1, c[0] = cin is used.
- Arithmetic is exact: {cout,sum} always equals a + b + cin as a WIDTH+1-bit unsigned value. No saturation.
- REG_OUT=1:
  - sum/cout/ovf are captured on the rising clk edge.
  - Latency is exactly 1 cycle from input change to output update.
  - A new operand set is accepted every cycle; throughput is 1 per cycle.
- REG_OUT=1, rst high at a clock edge:
  - sum=0, cout=0, ovf=0 at that edge, regardless of inputs.
  - Outputs hold 0 while rst stays high.
  - The first post-reset result appears at the first edge with rst low.
- REG_OUT=1, rst asserted mid-stream: the pending result is discarded and outputs clear at that edge.
- REG_OUT=0:
  - Outputs follow inputs combinationally with zero latency.
  - clk and rst are ignored.
  - No latches are permitted.
- Boundary (X inputs): X/Z on inputs need not be filtered. Outputs are don't-care until inputs are known.
- Boundary (all-ones with carry): a = b = all-ones and cin = 1 gives sum = all-ones, cout = 1.
- Boundary (zero): all-zero inputs give an all-zero result and cout = 0.

Decomposition:
- Shared package:
  - Default WIDTH constant.
  - A typedef for the {cout,sum} result vector of WIDTH+1 bits.
- Sub-module full_adder_bit (a, b, cin -> s, cout), a pure combinational 1-bit cell.
  - Instantiated WIDTH times via a generate loop.
  - The top level holds the carry wiring, ovf derivation and the REG_OUT generate branch containing the output register.

Test Plan:
- WIDTH=1, REG_OUT=0, exhaustive truth table with (cin,a,b) stepped 000..111 every 10 time units. Required (sum,cout), in order: 00, 10, 10, 01, 10, 01, 01, 11.
- WIDTH=1, REG_OUT=1, same 8 vectors applied one per clk. Each (sum,cout) appears exactly 1 edge after its inputs. Outputs are 0/0 at the edge where rst=1.
- WIDTH=8, REG_OUT=1, a=8'hFF, b=8'h01, cin=0 -> sum=8'h00, cout=1, ovf=0. Then a=8'h7F, b=8'h01, cin=0 -> sum=8'h80, cout=0, ovf=1.
- WIDTH=8, a=8'hFF, b=8'hFF, cin=1 -> sum=8'hFF, cout=1, ovf=0. Then a=8'h80, b=8'h80, cin=0 -> sum=8'h00, cout=1, ovf=1.
- Reset mid-stream, WIDTH=8, REG_OUT=1: stream random operands, assert rst for 2 cycles. Outputs are 0 on both reset edges, and the correct result resumes on the first edge after deassertion.
- Random regression, WIDTH=16, 10k vectors: {cout,sum} == a+b+cin. ovf matches the signed-overflow reference model, with REG_OUT=1 results checked one cycle later.
